// File: rtl/sevenseg_mux_driver.sv
// sevenseg_mux_driver: time-multiplexed N-digit seven-segment scanner with hex decode,
// leading-zero/per-digit blanking and frame-synchronous display update.
module sevenseg_mux_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYCLES = 2,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    output logic [6:0]              a_to_g,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);
    localparam int   CW  = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam int   IW  = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int   SW  = 6 * NUM_DIGITS;
    localparam logic INV = ACTIVE_LOW != 0;

    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [SW-1:0]         shadow_q, shadow_d, disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  fd_q, fd_d;

    logic [4*NUM_DIGITS-1:0] disp_val;
    logic [NUM_DIGITS-1:0]   disp_dp, disp_blank, lz, onehot;
    logic [3:0]              nib;
    logic                    tc, last, boundary, run, lit;

    function automatic logic [6:0] decode(input logic [3:0] h);
        case (h)
            4'h0: decode = 7'h7E;  4'h1: decode = 7'h30;  4'h2: decode = 7'h6D;  4'h3: decode = 7'h79;
            4'h4: decode = 7'h33;  4'h5: decode = 7'h5B;  4'h6: decode = 7'h5F;  4'h7: decode = 7'h70;
            4'h8: decode = 7'h7F;  4'h9: decode = 7'h7B;  4'hA: decode = 7'h77;  4'hB: decode = 7'h1F;
            4'hC: decode = 7'h4E;  4'hD: decode = 7'h3D;  4'hE: decode = 7'h4F;  default: decode = 7'h47;
        endcase
    endfunction

    assign disp_val   = disp_q[SW-1 -: 4*NUM_DIGITS];
    assign disp_dp    = disp_q[2*NUM_DIGITS-1:NUM_DIGITS];
    assign disp_blank = disp_q[NUM_DIGITS-1:0];

    always_comb begin
        tc        = cnt_q == CW'(REFRESH_DIV - 1);
        last      = idx_q == IW'(NUM_DIGITS - 1);
        boundary  = tc && last;
        cnt_d     = tc ? '0 : cnt_q + 1'b1;
        idx_d     = !tc ? idx_q : (last ? '0 : idx_q + 1'b1);
        shadow_d  = load ? {value, dp_in, blank} : shadow_q;
        // a load landing on the boundary bypasses the shadow so it shows next frame
        pending_d = boundary ? 1'b0 : (load || pending_q);
        disp_d    = !boundary ? disp_q : (load ? {value, dp_in, blank} : (pending_q ? shadow_q : disp_q));
        run       = 1'b1;
        lz        = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            run   = run && (disp_val[4*k +: 4] == 4'h0);
            lz[k] = run && k > 0 && LZ_BLANK != 0;
        end
        nib    = disp_val[idx_q*4 +: 4];
        onehot = NUM_DIGITS'(1) << idx_q;
        lit    = cnt_q >= CW'(DEAD_CYCLES) && !disp_blank[idx_q] && !lz[idx_q];
        an_d   = (lit ? onehot : '0) ^ {NUM_DIGITS{INV}};
        seg_d  = (lit ? decode(nib) : 7'h00) ^ {7{INV}};
        dp_d   = (lit && disp_dp[idx_q]) ^ INV;
        fd_d   = boundary;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= {7{INV}};
            dp_q      <= INV;
            an_q      <= {NUM_DIGITS{INV}};
            fd_q      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            fd_q      <= fd_d;
        end
    end

    assign a_to_g     = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// tb_sevenseg_mux_driver: directed scenarios for the 4-digit scanner (REFRESH_DIV=4, DEAD_CYCLES=1, active-low).
module tb_sevenseg_mux_driver;
    logic        clk = 1'b0, reset = 1'b1, load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0, blank = '0;
    logic [6:0]  a_to_g;
    logic        dp, frame_done;
    logic [3:0]  an;

    int n_cmp = 0, n_bad = 0;
    logic [3:0]  e_an[4];
    logic [6:0]  e_seg[4];
    logic        e_dp[4];
    logic [12:0] got, want;

    sevenseg_mux_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .DEAD_CYCLES(1), .ACTIVE_LOW(1), .LZ_BLANK(1)) dut (
        .clk(clk), .reset(reset), .value(value), .dp_in(dp_in), .blank(blank), .load(load),
        .a_to_g(a_to_g), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // expected pin levels for digit d given its active-high segment code
    task automatic exp_digit(input int d, input logic lit, input logic [6:0] seg_hi, input logic dp_lit);
        e_an[d]  = lit ? ~(4'b0001 << d) : 4'hF;
        e_seg[d] = lit ? ~seg_hi : 7'h7F;
        e_dp[d]  = ~(lit && dp_lit);
    endtask

    task automatic wait_fd();
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = frame_done;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL wait_fd: frame_done stayed 0, required 1 within 40 cycles");
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp_in = d; blank = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic check_pins(input string tag, input logic [12:0] w);
        got = {an, a_to_g, dp, frame_done};
        n_cmp++;
        if (got !== w) begin
            n_bad++;
            $display("FAIL %s: an=%b seg=%h dp=%b fd=%b, required an=%b seg=%h dp=%b fd=%b",
                     tag, got[12:9], got[8:2], got[1], got[0], w[12:9], w[8:2], w[1], w[0]);
        end
    endtask

    task automatic check_frame(input string tag);
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            want = (j % 4 == 0) ? {4'hF, 7'h7F, 1'b1, j == 15}
                                : {e_an[j/4], e_seg[j/4], e_dp[j/4], j == 15};
            check_pins($sformatf("%s j=%0d", tag, j), want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_pins("reset_held", {4'hF, 7'h7F, 1'b1, 1'b0});
        reset = 1'b0;
        @(negedge clk);
        check_pins("reset_dead_slot", {4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        check_pins("reset_first_lit", {4'b1110, ~7'h7E, 1'b1, 1'b0});
    endtask

    task automatic test_leading_zero();
        pulse_load(16'h0007, 4'h0, 4'h0);
        wait_fd();
        exp_digit(0, 1, 7'h70, 0); exp_digit(1, 0, 0, 0); exp_digit(2, 0, 0, 0); exp_digit(3, 0, 0, 0);
        check_frame("lz_0007");
        pulse_load(16'h0000, 4'h0, 4'h0);
        wait_fd();
        exp_digit(0, 1, 7'h7E, 0);
        check_frame("lz_0000");
        pulse_load(16'h0100, 4'h0, 4'h0);
        wait_fd();
        exp_digit(0, 1, 7'h7E, 0); exp_digit(1, 1, 7'h7E, 0); exp_digit(2, 1, 7'h30, 0); exp_digit(3, 0, 0, 0);
        check_frame("lz_0100");
    endtask

    task automatic test_value();
        pulse_load(16'h1234, 4'h0, 4'h0);
        wait_fd();
        exp_digit(0, 1, 7'h33, 0); exp_digit(1, 1, 7'h79, 0); exp_digit(2, 1, 7'h6D, 0); exp_digit(3, 1, 7'h30, 0);
        check_frame("val_1234_a");
        check_frame("val_1234_b");
    endtask

    task automatic test_midframe();
        wait_fd();
        for (int j = 0; j < 32; j++) begin
            @(negedge clk);
            load = 1'b0;
            want = (j % 4 == 0) ? {4'hF, 7'h7F, 1'b1, j % 16 == 15}
                                : {e_an[(j%16)/4], e_seg[(j%16)/4], e_dp[(j%16)/4], j % 16 == 15};
            check_pins($sformatf("midframe j=%0d", j), want);
            if (j == 5) begin
                value = 16'hABCD; dp_in = 4'h0; blank = 4'h0; load = 1'b1;
            end
            if (j == 15) begin
                exp_digit(0, 1, 7'h3D, 0); exp_digit(1, 1, 7'h4E, 0); exp_digit(2, 1, 7'h1F, 0); exp_digit(3, 1, 7'h77, 0);
            end
        end
    endtask

    task automatic test_boundary_load();
        wait_fd();
        repeat (15) @(negedge clk);
        value = 16'h5678; dp_in = 4'b0100; blank = 4'b0010; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        n_cmp++;
        if (frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL boundary_align: frame_done=%b required 1", frame_done);
        end
        exp_digit(0, 1, 7'h7F, 0); exp_digit(1, 0, 0, 0); exp_digit(2, 1, 7'h5F, 1); exp_digit(3, 1, 7'h5B, 0);
        check_frame("boundary_5678");
        check_frame("boundary_5678_hold");
    endtask

    task automatic test_reset_midframe();
        wait_fd();
        repeat (10) @(negedge clk);
        check_pins("pre_reset_digit2", {4'b1011, ~7'h5F, 1'b0, 1'b0});
        reset = 1'b1;
        #1;
        check_pins("reset_async", {4'hF, 7'h7F, 1'b1, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        exp_digit(0, 1, 7'h7E, 0); exp_digit(1, 0, 0, 0); exp_digit(2, 0, 0, 0); exp_digit(3, 0, 0, 0);
        check_frame("after_reset");
    endtask

    initial begin
        test_reset();
        test_leading_zero();
        test_value();
        test_midframe();
        test_boundary_load();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
